serial_sequence_detector: RTL and testbench
===========================================

# serial_sequence_detector

Downstream consumer of the negative-edge D flip-flop's registered serial output `q`. Samples that bit on the rising clock edge, half a cycle after the flop updates. Detects the serial pattern 1011 with a Moore-style FSM, emits a one-cycle match pulse and keeps a saturating count of matches.

## Interface
- `CNT_W`, default 8: width of the match counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial data bit, driven by the upstream flop's `q`.
- `din_valid`  in  1  qualifies `din`; a bit is consumed only on an edge where this is 1.
- `clr`  in  1  synchronous clear of `match_count`.
- `match`  out  1  registered pulse; 1 for exactly one cycle per detected pattern.
- `match_count`  out  CNT_W  number of matches since reset or `clr`; saturates.
- `state`  out  3  current FSM state encoding, for debug observation.

## Operation
- States: `S_IDLE` (no prefix), `S_1`, `S_10`, `S_101`, `S_1011` (pattern complete).
- Transitions on a consumed bit (0 / 1):
  - `S_IDLE`: 0 → `S_IDLE`, 1 → `S_1`.
  - `S_1`: 0 → `S_10`, 1 → `S_1`.
  - `S_10`: 0 → `S_IDLE`, 1 → `S_101`.
  - `S_101`: 0 → `S_10`, 1 → `S_1011`.
  - `S_1011`: 1 → `S_1`; the 0 target depends on the configuration.
- `din_valid` = 0:
  - The state holds.
  - `match` is 0.
  - The counter holds.
- `match` is registered and set to 1 on the edge where a consumed bit moves the FSM into `S_1011`. It is 0 on every other edge.
- `match_count` increments on the same edge that sets `match`.
- The counter saturates at 2^CNT_W−1: further matches still pulse `match`, but the count does not wrap.
- `clr` = 1:
  - `match_count` becomes 0 on that edge.
  - `clr` wins over a simultaneous increment, so the result is 0, not 1.
  - `match` and the FSM are unaffected by `clr`.
- Reset (`rst` = 0, asynchronous and immediate):
  - state = `S_IDLE`, `match` = 0, `match_count` = 0.
  - A reset during a partial pattern discards the prefix.

## Timing
- Latency: `match` is high during the cycle that follows the rising edge that sampled the 4th pattern bit.
- Back-to-back matches in overlap mode (pattern 1011011) produce `match` pulses 3 consumed bits apart.
- `din` must be stable around the rising edge. The upstream negedge flop guarantees half a cycle of setup.
- Reset release is synchronous to `clk` at system level. The first bit is consumed on the first rising edge with `rst` = 1.

## Configuration
- `SEQ_DET_OVERLAP_EN` defined: overlapping detection. From `S_1011`, a 0 goes to `S_10`, so the trailing 1 is reused.
- `SEQ_DET_OVERLAP_EN` undefined: non-overlapping detection. From `S_1011`, a 0 goes to `S_IDLE`, so no bits of a completed match are reused.

## Structure
- Shared package `seq_det_pkg` holds:
  - the state encoding constants/typedef (3-bit) for `S_IDLE` through `S_1011`;
  - the pattern constant `SEQ_PATTERN` = 4'b1011;
  - the pattern length constant = 4.
- Sub-module `seq_match_counter`:
  - parameterised by `CNT_W`;
  - inputs `clk`, `rst`, `inc`, `clr`; output `count`;
  - implements saturating increment with `clr` priority.
- The top level contains the FSM, the match register and the counter instance.

## Test plan
- Reset with stream 1,0,1,1 (valid every cycle) applied, then `rst` = 0 mid-stream → `match` = 0, `match_count` = 0 and state = `S_IDLE` immediately. After release, 1,0,1,1 gives one `match` pulse, one cycle after the 4th edge.
- Stream 1,0,1,1,0,1,1 → with `SEQ_DET_OVERLAP_EN`: 2 pulses, `match_count` = 2. Without it: 1 pulse, `match_count` = 1.
- Stream 1,0,1,1 with `din_valid` = 0 for 3 cycles between bits 2 and 3 → state holds at `S_10`, `match` stays 0 during the gap, and exactly 1 pulse follows the 4th valid bit.
- Near-miss stream 1,0,0,1,0,1,0 → `match` never asserted, `match_count` = 0, final state = `S_10`.
- `CNT_W` = 2, five separated 1011 patterns → `match_count` goes 1, 2, 3, 3, 3 and `match` pulses 5 times.
- `clr` = 1 on the same edge as a match with `match_count` = 2 → `match_count` = 0, `match` = 1 for that cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial 1011 detector.
// Build option: SEQ_DET_OVERLAP_EN selects overlapping detection (default: non-overlapping).
package seq_det_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_10   = 3'd2,
    S_101  = 3'd3,
    S_1011 = 3'd4
  } state_t;

  localparam logic [3:0] SEQ_PATTERN = 4'b1011;
  localparam int         SEQ_LEN     = 4;

  // Each state is "how many pattern bits matched so far"; on a miss, fall back to the
  // longest suffix of the received bits that is still a prefix of 1011.
  function automatic state_t next_state(input state_t cur, input logic b);
    state_t nxt;
    case (cur)
      S_IDLE:  nxt = (b == SEQ_PATTERN[SEQ_LEN-1]) ? S_1    : S_IDLE;
      S_1:     nxt = (b == SEQ_PATTERN[SEQ_LEN-2]) ? S_10   : S_1;
      S_10:    nxt = (b == SEQ_PATTERN[SEQ_LEN-3]) ? S_101  : S_IDLE;
      S_101:   nxt = (b == SEQ_PATTERN[SEQ_LEN-4]) ? S_1011 : S_10;
`ifdef SEQ_DET_OVERLAP_EN
      S_1011:  nxt = b ? S_1 : S_10;
`else
      S_1011:  nxt = b ? S_1 : S_IDLE;
`endif
      default: nxt = S_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter; synchronous clear has priority over increment.
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc)
      count <= sat_inc(count);
  end

endmodule

// File: rtl/serial_sequence_detector.sv
// Moore-style 1011 detector on a qualified serial stream, with registered match pulse.
// Build option: SEQ_DET_OVERLAP_EN enables overlapping detection.
module serial_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [2:0]       state
);

  state_t cur;
  state_t nxt;
  logic   hit;

  // Entering S_1011 on a consumed bit is the match event for both the pulse and the counter.
  always_comb begin
    nxt = next_state(cur, din);
    hit = din_valid && (nxt == S_1011);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur   <= S_IDLE;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (din_valid)
        cur <= nxt;
    end
  end

  assign state = cur;

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (clr),
    .count (match_count)
  );

endmodule

// File: tb/tb_serial_sequence_detector.sv
// Directed-vector bench for serial_sequence_detector (8-bit and 2-bit counter instances).
module tb_serial_sequence_detector;
  import seq_det_pkg::*;

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, din, din_valid, clr;
  logic       match8, match2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [2:0] st8, st2;

  int checks = 0;
  int errors = 0;
  int pulses8, pulses2;

  always #5 clk = ~clk;

  serial_sequence_detector #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .match(match8), .match_count(cnt8), .state(st8)
  );

  serial_sequence_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .match(match2), .match_count(cnt2), .state(st2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic send(input logic b);
    din       = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    pulses8 += int'(match8);
    pulses2 += int'(match2);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      pulses8 += int'(match8);
      pulses2 += int'(match2);
    end
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    rst       = 1'b0;
    #2;
    rst       = 1'b1;
    pulses8   = 0;
    pulses2   = 0;
  endtask

  task automatic send_pattern();
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
  endtask

  int exp2 [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b0; din = 1'b0; din_valid = 1'b0; clr = 1'b0;
    pulses8 = 0; pulses2 = 0;
    @(posedge clk);
    #1;
    check("reset_state", st8, S_IDLE);
    check("reset_match", match8, 0);
    check("reset_count", cnt8, 0);
    rst = 1'b1;

    // Mid-stream reset clears match, count and state immediately.
    send(1'b1); send(1'b0); send(1'b1);
    check("prefix_state", st8, S_101);
    check("prefix_match", match8, 0);
    send(1'b1);
    check("first_match", match8, 1);
    check("first_count", cnt8, 1);
    check("first_state", st8, S_1011);
    rst = 1'b0;
    #1;
    check("async_rst_match", match8, 0);
    check("async_rst_count", cnt8, 0);
    check("async_rst_state", st8, S_IDLE);
    rst = 1'b1;
    pulses8 = 0; pulses2 = 0;

    // A discarded prefix does not complete a match.
    send(1'b1); send(1'b0); send(1'b1);
    do_reset();
    send(1'b1);
    check("discard_state", st8, S_1);
    check("discard_match", match8, 0);

    do_reset();
    send(1'b1); send(1'b0); send(1'b1);
    check("rel_no_early", match8, 0);
    send(1'b1);
    check("rel_match", match8, 1);
    idle(1);
    check("rel_pulse_end", match8, 0);
    check("rel_pulses", pulses8, 1);

    // 1011011: overlap-dependent pulse count.
    do_reset();
    send_pattern();
    check("ovl_first", match8, 1);
    send(1'b0); send(1'b1);
    check("ovl_mid_match", match8, 0);
    send(1'b1);
    check("ovl_second", match8, OVR ? 1 : 0);
    check("ovl_state", st8, OVR ? S_1011 : S_1);
    idle(1);
    check("ovl_pulses", pulses8, OVR ? 2 : 1);
    check("ovl_count", cnt8, OVR ? 2 : 1);

    // Valid gap between bits 2 and 3 holds state.
    do_reset();
    send(1'b1); send(1'b0);
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      idle(1);
      check("gap_state", st8, S_10);
      check("gap_match", match8, 0);
    end
    send(1'b1); send(1'b1);
    check("gap_final_match", match8, 1);
    idle(1);
    check("gap_pulses", pulses8, 1);
    check("gap_count", cnt8, 1);

    // Near miss 1,0,0,1,0,1,0.
    do_reset();
    send(1'b1); send(1'b0); send(1'b0); send(1'b1); send(1'b0); send(1'b1); send(1'b0);
    idle(1);
    check("near_pulses", pulses8, 0);
    check("near_count", cnt8, 0);
    check("near_state", st8, S_10);

    // Saturation of the 2-bit counter across five separated matches.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_pattern();
      check("sat_match2", match2, 1);
      check("sat_count2", cnt2, exp2[k]);
      check("sat_count8", cnt8, k + 1);
      idle(2);
    end
    check("sat_pulses2", pulses2, 5);

    // clr on the same edge as a match wins over the increment.
    do_reset();
    send_pattern(); idle(1);
    send_pattern(); idle(1);
    check("clr_pre_count", cnt8, 2);
    send(1'b1); send(1'b0); send(1'b1);
    clr = 1'b1;
    send(1'b1);
    clr = 1'b0;
    check("clr_match", match8, 1);
    check("clr_count8", cnt8, 0);
    check("clr_count2", cnt2, 0);
    check("clr_state", st8, S_1011);
    idle(1);
    check("clr_after_match", match8, 0);
    check("clr_after_count", cnt8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
